// File: rtl/regfile_sb.sv
// regfile_sb -- general register file with a pending-write scoreboard.
//
// Decode-stage register file: NRD combinational read ports, one write port,
// optional same-cycle write-to-read forwarding and one pending-write bit per
// register.  The control FSM uses the per-port busy flags to stall on RAW
// hazards against instructions that are still in flight.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   ra_i          NRD read addresses, port k = ra_i[k*AW +: AW]
//   rd_o          NRD read data,      port k = rd_o[k*DW +: DW]
//   rbusy_o       per-port pending-write flag for the addressed register
//   regwrite_i    write enable; wa_i / wd_i write address / data
//   issue_i       a producer of issue_wa_i has been issued
//   flush_i       synchronous clear of every scoreboard bit
//   busy_o        scoreboard vector, bit r = register r pending
//   dbg_o         raw contents of register DBG_IDX (never forwarded)

// One general register plus its scoreboard bit.
//   we     write strobe already qualified for this register
//   issue  issue strobe already qualified for this register
//   flush  pipeline flush
//   q      stored value, busy  pending-write flag
module regfile_sb_cell #(
  parameter int             DW      = 32,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [DW-1:0] wd,
  input  logic          issue,
  input  logic          flush,
  output logic [DW-1:0] q,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} sb_state_t;

  sb_state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else if (we) q <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Flush beats everything; an issue beats a same-cycle writeback because a
  // newer producer of this register is now in flight.  A writeback while
  // IDLE is legal and leaves the state alone.
  always_comb begin
    state_nxt = state;
    busy      = (state == PEND);
    if (flush)      state_nxt = IDLE;
    else if (issue) state_nxt = PEND;
    else if (we)    state_nxt = IDLE;
  end

endmodule

// One read port: register select plus optional forwarding of the write bus.
//   ra        read address
//   regs      all register values (entry 0 tied to zero at the top)
//   busy      scoreboard vector (bit 0 tied to zero at the top)
//   regwrite, wa, wd   current write bus
//   rd, rbusy read data and pending flag for this port
module regfile_sb_rport #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [AW-1:0]                 ra,
  input  logic [(1<<AW)-1:0][DW-1:0]    regs,
  input  logic [(1<<AW)-1:0]            busy,
  input  logic                          regwrite,
  input  logic [AW-1:0]                 wa,
  input  logic [DW-1:0]                 wd,
  output logic [DW-1:0]                 rd,
  output logic                          rbusy
);

  logic fwd;

  // A matching write this cycle already carries the value, so the register
  // is no longer a hazard for this reader.
  assign fwd   = BYPASS && regwrite && (wa == ra) && (wa != '0);
  assign rd    = fwd ? wd   : regs[ra];
  assign rbusy = fwd ? 1'b0 : busy[ra];

endmodule

module regfile_sb #(
  parameter int             DW      = 32,
  parameter int             AW      = 5,
  parameter int             NRD     = 2,
  parameter bit             BYPASS  = 1'b1,
  parameter int             GP_IDX  = 28,
  parameter logic [DW-1:0]  GP_INIT = 'h0000_1800,
  parameter int             SP_IDX  = 29,
  parameter logic [DW-1:0]  SP_INIT = 'h0000_2ffc,
  parameter int             DBG_IDX = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    ra_i,
  output logic [NRD*DW-1:0]    rd_o,
  output logic [NRD-1:0]       rbusy_o,
  input  logic                 regwrite_i,
  input  logic [AW-1:0]        wa_i,
  input  logic [DW-1:0]        wd_i,
  input  logic                 issue_i,
  input  logic [AW-1:0]        issue_wa_i,
  input  logic                 flush_i,
  output logic [(1<<AW)-1:0]   busy_o,
  output logic [DW-1:0]        dbg_o
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] DBG_A = AW'(DBG_IDX);

  logic [DEPTH-1:0][DW-1:0] regs;
  logic [DEPTH-1:0]         busy;

  // r0 is hard-wired: no storage, never pending, writes and issues ignored.
  assign regs[0] = '0;
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_reg
    localparam logic [AW-1:0] IDX = AW'(r);
    localparam logic [DW-1:0] RV  = (r == GP_IDX) ? GP_INIT :
                                    (r == SP_IDX) ? SP_INIT : '0;
    regfile_sb_cell #(.DW(DW), .RST_VAL(RV)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (regwrite_i && (wa_i == IDX)),
      .wd    (wd_i),
      .issue (issue_i && (issue_wa_i == IDX)),
      .flush (flush_i),
      .q     (regs[r]),
      .busy  (busy[r])
    );
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rport
    regfile_sb_rport #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_rport (
      .ra       (ra_i[k*AW +: AW]),
      .regs     (regs),
      .busy     (busy),
      .regwrite (regwrite_i),
      .wa       (wa_i),
      .wd       (wd_i),
      .rd       (rd_o[k*DW +: DW]),
      .rbusy    (rbusy_o[k])
    );
  end

  assign busy_o = busy;
  assign dbg_o  = regs[DBG_A];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 4-port forwarding instance and a 2-port
// non-forwarding instance share one stimulus stream.  A behavioural model
// (array of register values plus a pending set) is compared against both
// DUTs on every falling edge; directed literal checks pin the model.
module tb_regfile_sb;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0][4:0]  ra;
  logic             regwrite, issue, flush;
  logic [4:0]       wa, issue_wa;
  logic [31:0]      wd;

  logic [4*32-1:0]  rd_b1;
  logic [3:0]       rbusy_b1;
  logic [31:0]      busy_b1, dbg_b1;
  logic [2*32-1:0]  rd_b0;
  logic [1:0]       rbusy_b0;
  logic [31:0]      busy_b0, dbg_b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb #(.NRD(4), .BYPASS(1'b1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .ra_i(ra), .rd_o(rd_b1), .rbusy_o(rbusy_b1),
    .regwrite_i(regwrite), .wa_i(wa), .wd_i(wd), .issue_i(issue),
    .issue_wa_i(issue_wa), .flush_i(flush), .busy_o(busy_b1), .dbg_o(dbg_b1));

  regfile_sb #(.NRD(2), .BYPASS(1'b0)) u_b0 (
    .clk(clk), .rst_n(rst_n), .ra_i(ra[1:0]), .rd_o(rd_b0), .rbusy_o(rbusy_b0),
    .regwrite_i(regwrite), .wa_i(wa), .wd_i(wd), .issue_i(issue),
    .issue_wa_i(issue_wa), .flush_i(flush), .busy_o(busy_b0), .dbg_o(dbg_b0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem [32];
  logic [31:0] pend;
  bit          mdl_ok = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      mem[28] = 32'h0000_1800;
      mem[29] = 32'h0000_2ffc;
      pend    = 32'h0;
      mdl_ok  = 1'b1;
    end else begin
      logic [31:0] nxt;
      nxt = pend;
      if (regwrite && wa != 5'd0) begin
        mem[wa] = wd;
        nxt[wa] = 1'b0;
      end
      if (issue) nxt[issue_wa] = 1'b1;
      if (flush) nxt = 32'h0;
      nxt[0] = 1'b0;
      pend   = nxt;
    end
  end

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (byp && regwrite && wa == a) return wd;
    return mem[a];
  endfunction

  function automatic logic exp_rbusy(input bit byp, input logic [4:0] a);
    if (byp && regwrite && wa == a && a != 5'd0) return 1'b0;
    return pend[a];
  endfunction

  always @(negedge clk) begin
    if (mdl_ok) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("b1 rd%0d", k), rd_b1[k*32 +: 32], exp_rd(1'b1, ra[k]));
        chk($sformatf("b1 rbusy%0d", k), {31'h0, rbusy_b1[k]}, {31'h0, exp_rbusy(1'b1, ra[k])});
      end
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("b0 rd%0d", k), rd_b0[k*32 +: 32], exp_rd(1'b0, ra[k]));
        chk($sformatf("b0 rbusy%0d", k), {31'h0, rbusy_b0[k]}, {31'h0, exp_rbusy(1'b0, ra[k])});
      end
      chk("b1 busy", busy_b1, pend);
      chk("b0 busy", busy_b0, pend);
      chk("b1 dbg", dbg_b1, mem[3]);
      chk("b0 dbg", dbg_b0, mem[3]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    regwrite = 1'b0; issue = 1'b0; flush = 1'b0;
    wa = 5'd0; wd = 32'h0; issue_wa = 5'd0;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    ra = {5'd0, 5'd5, 5'd29, 5'd28};
    #2 rst_n = 1'b0;
    #1;
    chk("por rd r28", rd_b1[31:0],  32'h0000_1800);
    chk("por rd r29", rd_b1[63:32], 32'h0000_2ffc);
    chk("por rd r5",  rd_b1[95:64], 32'h0);
    chk("por busy",   busy_b1,      32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // write / read, r0 writes dropped
    regwrite = 1'b1; wa = 5'd7; wd = 32'hDEAD_BEEF;
    tick(); idle(); ra[0] = 5'd7; #2;
    chk("r7 readback", rd_b0[31:0], 32'hDEAD_BEEF);
    regwrite = 1'b1; wa = 5'd0; wd = 32'h1234; ra[0] = 5'd0;
    tick(); idle(); #2;
    chk("r0 reads 0", rd_b1[31:0], 32'h0);

    // bypass vs no bypass, r9 made pending first
    issue = 1'b1; issue_wa = 5'd9;
    tick(); idle(); ra[1] = 5'd9;
    regwrite = 1'b1; wa = 5'd9; wd = 32'h55; #2;
    chk("byp rd1",       rd_b1[63:32],         32'h55);
    chk("byp rbusy1",    {31'h0, rbusy_b1[1]}, 32'h0);
    chk("nobyp rd1 old", rd_b0[63:32],         32'h0);
    chk("nobyp rbusy1",  {31'h0, rbusy_b0[1]}, 32'h1);
    tick(); idle(); #2;
    chk("nobyp rd1 new", rd_b0[63:32], 32'h55);

    // scoreboard
    issue = 1'b1; issue_wa = 5'd12;
    tick(); idle(); ra[0] = 5'd12; #2;
    chk("busy12 set", busy_b1, 32'h0000_1000);
    chk("rbusy0 r12", {31'h0, rbusy_b0[0]}, 32'h1);
    regwrite = 1'b1; wa = 5'd12; wd = 32'h77;
    tick(); idle(); #2;
    chk("busy12 clr", busy_b1, 32'h0);
    regwrite = 1'b1; wa = 5'd12; wd = 32'hABC; issue = 1'b1; issue_wa = 5'd12;
    tick(); idle(); #2;
    chk("wb+issue busy", busy_b0, 32'h0000_1000);
    chk("wb+issue data", rd_b0[31:0], 32'hABC);

    // flush
    issue = 1'b1; issue_wa = 5'd3; tick();
    issue_wa = 5'd4; tick();
    issue_wa = 5'd5; tick(); idle(); #2;
    chk("busy 3/4/5/12", busy_b1, 32'h0000_1038);
    flush = 1'b1; issue = 1'b1; issue_wa = 5'd6;
    tick(); idle(); #2;
    chk("flush wins", busy_b1, 32'h0);
    issue = 1'b1; issue_wa = 5'd0;
    tick(); idle(); #2;
    chk("issue r0", busy_b0, 32'h0);

    // multiport and debug port
    ra = {5'd29, 5'd29, 5'd29, 5'd29}; #1;
    chk("mp all r29", {rd_b1[31:0] ^ rd_b1[63:32], rd_b1[95:64] ^ rd_b1[127:96]} == 64'h0
                      ? rd_b1[127:96] : 32'hFFFF_FFFF, 32'h0000_2ffc);
    chk("mp port0 r29", rd_b1[31:0], 32'h0000_2ffc);
    regwrite = 1'b1; wa = 5'd3; wd = 32'hA5A5_A5A5;
    tick(); idle(); #2;
    chk("dbg b1", dbg_b1, 32'hA5A5_A5A5);
    chk("dbg b0", dbg_b0, 32'hA5A5_A5A5);

    // reset in the middle of activity
    regwrite = 1'b1; wa = 5'd28; wd = 32'h99; tick();
    wa = 5'd5; wd = 32'h5; issue = 1'b1; issue_wa = 5'd17; tick(); idle();
    ra = {5'd3, 5'd5, 5'd29, 5'd28}; #1;
    chk("pre-rst r28", rd_b1[31:0], 32'h99);
    rst_n = 1'b0; #1;
    chk("mid rst r28",  rd_b1[31:0],   32'h0000_1800);
    chk("mid rst r29",  rd_b1[63:32],  32'h0000_2ffc);
    chk("mid rst r5",   rd_b1[95:64],  32'h0);
    chk("mid rst r3",   rd_b1[127:96], 32'h0);
    chk("mid rst busy", busy_b0,       32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
